uart_rx_os16: RTL

UART_RX_OS16 -- requirements
Module: uart_rx_os16

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_os16_if.sv | 23 ++
 rtl/uart_baud_tick.sv | 34 +++
 rtl/uart_rx_os16.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for uart_rx_os16; UART_RX_PARITY_EN adds the PARITY state
package uart_pkg;

   localparam int UART_DATA_BITS  = 8;
   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_MID_SAMPLE = 7;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_HIGH
   } uart_state_e;
`else
   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_WAIT_HIGH
   } uart_state_e;
`endif

   // Even parity: data ones plus the parity bit must come to an even count.
   function automatic logic even_parity_err(input logic [UART_DATA_BITS-1:0] data,
                                            input logic                      par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/uart_rx_os16_if.sv
// rtl/uart_rx_os16_if.sv - received-byte handshake bundle; parity_err_o present with UART_RX_PARITY_EN
interface uart_rx_os16_if;
   import uart_pkg::*;

   logic [UART_DATA_BITS-1:0] data_o;
   logic                      valid_o;
   logic                      ready_i;
   logic                      frame_err_o;
   logic                      overrun_o;
`ifdef UART_RX_PARITY_EN
   logic                      parity_err_o;

   modport master (output data_o, valid_o, frame_err_o, overrun_o, parity_err_o,
                   input  ready_i);
   modport slave  (input  data_o, valid_o, frame_err_o, overrun_o, parity_err_o,
                   output ready_i);
`else
   modport master (output data_o, valid_o, frame_err_o, overrun_o,
                   input  ready_i);
   modport slave  (input  data_o, valid_o, frame_err_o, overrun_o,
                   output ready_i);
`endif
endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running CLK_DIV divider producing a one-cycle oversample tick
module uart_baud_tick #(
   parameter int CLK_DIV = 27
) (
   input  logic r_clk,
   input  logic r_reset_n,
   input  logic restart_i,
   output logic tick_o
);

   logic [15:0] cnt_q, cnt_d;
   logic        at_end;

   // Count to CLK_DIV-1 and wrap; a restart realigns the phase to the start edge.
   always_comb begin
      at_end = (cnt_q == 16'(CLK_DIV - 1));
      cnt_d  = cnt_q + 16'd1;
      if (restart_i || at_end) begin
         cnt_d = '0;
      end
   end

   assign tick_o = at_end && !restart_i;

   // Divider counter register.
   always_ff @(posedge r_clk or negedge r_reset_n) begin
      if (!r_reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_rx_os16.sv
// rtl/uart_rx_os16.sv - 16x oversampling 8N1 UART receiver with valid/ready output; UART_RX_PARITY_EN adds even parity
module uart_rx_os16 #(
   parameter int CLK_DIV = 27
) (
   input  logic           r_clk,
   input  logic           r_reset_n,
   input  logic           serial_i,
   uart_rx_os16_if.master rx_if
);
   import uart_pkg::*;

   localparam logic [3:0] LAST_TICK = 4'(UART_OVERSAMPLE - 1);
   localparam logic [3:0] MID_TICK  = 4'(UART_MID_SAMPLE);
   localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);

   uart_state_e state_q, state_d;
   logic       sync1_q, sync1_d, sync2_q, sync2_d;
   logic [3:0] tick_cnt_q, tick_cnt_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic [7:0] shift_q, shift_d, data_q, data_d;
   logic       valid_q, valid_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
   logic       rx, tick, restart, load, load_fe, xfer;
`ifdef UART_RX_PARITY_EN
   logic       par_flag_q, par_flag_d, par_err_q, par_err_d;
`endif

   assign rx = sync2_q;

   uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .r_clk     (r_clk),
      .r_reset_n (r_reset_n),
      .restart_i (restart),
      .tick_o    (tick)
   );

   // Frame sequencing: start qualification, mid-bit sampling, stop check.
   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      restart    = 1'b0;
      load       = 1'b0;
      load_fe    = 1'b0;
      sync1_d    = serial_i;
      sync2_d    = sync1_q;
`ifdef UART_RX_PARITY_EN
      par_flag_d = par_flag_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!rx) begin
               state_d    = ST_START;
               tick_cnt_d = '0;
               restart    = 1'b1;
            end
         end
         ST_START: begin
            if (tick) begin
               if (tick_cnt_q == MID_TICK) begin
                  tick_cnt_d = '0;
                  bit_idx_d  = '0;
                  state_d    = rx ? ST_IDLE : ST_DATA;
               end else begin
                  tick_cnt_d = tick_cnt_q + 4'd1;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (tick_cnt_q == LAST_TICK) begin
                  tick_cnt_d = '0;
                  shift_d    = {rx, shift_q[7:1]};
                  bit_idx_d  = bit_idx_q + 3'd1;
                  if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                     state_d = ST_PARITY;
`else
                     state_d = ST_STOP;
`endif
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 4'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               if (tick_cnt_q == LAST_TICK) begin
                  tick_cnt_d = '0;
                  par_flag_d = even_parity_err(shift_q, rx);
                  state_d    = ST_STOP;
               end else begin
                  tick_cnt_d = tick_cnt_q + 4'd1;
               end
            end
         end
`endif
         ST_STOP: begin
            if (tick) begin
               if (tick_cnt_q == LAST_TICK) begin
                  tick_cnt_d = '0;
                  load       = 1'b1;
                  load_fe    = !rx;
                  state_d    = rx ? ST_IDLE : ST_WAIT_HIGH;
               end else begin
                  tick_cnt_d = tick_cnt_q + 4'd1;
               end
            end
         end
         ST_WAIT_HIGH: begin
            if (rx) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output holding register: a new byte wins over a same-cycle transfer, else it is dropped.
   always_comb begin
      xfer        = valid_q && rx_if.ready_i;
      data_d      = data_q;
      valid_d     = valid_q;
      frame_err_d = frame_err_q;
      overrun_d   = overrun_q;
`ifdef UART_RX_PARITY_EN
      par_err_d   = par_err_q;
`endif
      if (load) begin
         if (!valid_q || xfer) begin
            data_d      = shift_q;
            valid_d     = 1'b1;
            frame_err_d = load_fe;
`ifdef UART_RX_PARITY_EN
            par_err_d   = par_flag_q;
`endif
         end else begin
            overrun_d = 1'b1;
         end
      end else if (xfer) begin
         valid_d = 1'b0;
      end
   end

   // State, synchronizer and output registers.
   always_ff @(posedge r_clk or negedge r_reset_n) begin
      if (!r_reset_n) begin
         state_q     <= ST_IDLE;
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         tick_cnt_q  <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_flag_q  <= 1'b0;
         par_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         tick_cnt_q  <= tick_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
         par_flag_q  <= par_flag_d;
         par_err_q   <= par_err_d;
`endif
      end
   end

   assign rx_if.data_o      = data_q;
   assign rx_if.valid_o     = valid_q;
   assign rx_if.frame_err_o = frame_err_q;
   assign rx_if.overrun_o   = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign rx_if.parity_err_o = par_err_q;
`endif

endmodule
